// File: rtl/output_argmax_led.sv
`default_nettype none
// ============================================================================
// Module   : output_argmax_led
// Purpose  : Serial argmax over NUM_CLASSES signed scores; reports the winning
//            index and drives an active-low one-hot LED for HOLD_CYCLES cycles.
//            Optional OUTPUT_ARGMAX_LED_MATCH_EN adds exp_idx / match_led_n.
// Revision : 1.0
// ============================================================================
module output_argmax_led #(
    parameter int          NUM_CLASSES = 10,
    parameter int          SCORE_W     = 8,
    parameter logic [31:0] HOLD_CYCLES = 32'd75000,
    localparam int         IDX_W       = $clog2(NUM_CLASSES)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           din_valid,
    input  logic [NUM_CLASSES*SCORE_W-1:0] din,
    output logic                           busy,
    output logic                           result_valid,
    output logic [IDX_W-1:0]               result_idx,
    output logic [NUM_CLASSES-1:0]         led_n
`ifdef OUTPUT_ARGMAX_LED_MATCH_EN
    ,
    input  logic [IDX_W-1:0]               exp_idx,
    output logic                           match_led_n
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0]       c_last_idx = IDX_W'(NUM_CLASSES - 1);
    localparam logic [IDX_W-1:0]       c_first_i  = IDX_W'(1);
    localparam logic [NUM_CLASSES-1:0] c_one_hot0 = NUM_CLASSES'(1);

    state_t                    r_state;
    logic                      r_busy;
    logic                      r_result_valid;
    logic [IDX_W-1:0]          r_result_idx;
    logic [NUM_CLASSES-1:0]    r_led_n;
    logic [31:0]               r_cnt;
    logic [IDX_W-1:0]          r_i;
    logic [IDX_W-1:0]          r_best_idx;
    logic signed [SCORE_W-1:0] r_best_val;
    logic signed [SCORE_W-1:0] r_scores [NUM_CLASSES];

    logic signed [SCORE_W-1:0] w_cur;
    logic                      w_greater;
    logic [31:0]               w_cnt_next;
    logic [IDX_W-1:0]          w_idx_next;
    logic [NUM_CLASSES-1:0]    w_led_next;

    assign w_cur     = r_scores[r_i];
    assign w_greater = (w_cur > r_best_val);

    // Next hold count and index drive the registered LED so the lamp lights
    // in the same cycle result_valid rises and stays lit for HOLD_CYCLES cycles.
    always_comb begin
        w_cnt_next = r_cnt;
        w_idx_next = r_result_idx;
        if (r_state == S_DONE) begin
            w_cnt_next = HOLD_CYCLES;
            w_idx_next = r_best_idx;
        end else if (r_cnt != 32'd0) begin
            w_cnt_next = r_cnt - 32'd1;
        end
        w_led_next = (w_cnt_next != 32'd0) ? ~(c_one_hot0 << w_idx_next) : '1;
    end

    // Score data path needs no reset: it is always reloaded on acceptance.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && din_valid) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                r_scores[k] <= din[k*SCORE_W +: SCORE_W];
            end
            r_best_val <= din[SCORE_W-1:0];
        end else if (r_state == S_SCAN && w_greater) begin
            r_best_val <= w_cur;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_result_idx   <= '0;
            r_led_n        <= '1;
            r_cnt          <= 32'd0;
            r_i            <= '0;
            r_best_idx     <= '0;
        end else begin
            r_result_valid <= 1'b0;
            r_cnt          <= w_cnt_next;
            r_led_n        <= w_led_next;
            case (r_state)
                S_IDLE: begin
                    if (din_valid) begin
                        r_state    <= S_SCAN;
                        r_busy     <= 1'b1;
                        r_best_idx <= '0;
                        r_i        <= c_first_i;
                    end
                end
                S_SCAN: begin
                    if (w_greater) begin
                        r_best_idx <= r_i;
                    end
                    r_i <= r_i + 1'b1;
                    if (r_i == c_last_idx) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_result_valid <= 1'b1;
                    r_result_idx   <= r_best_idx;
                    r_busy         <= 1'b0;
                    r_state        <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign result_valid = r_result_valid;
    assign result_idx   = r_result_idx;
    assign led_n        = r_led_n;

`ifdef OUTPUT_ARGMAX_LED_MATCH_EN
    logic r_match_flag;
    logic r_match_led_n;
    logic w_flag_next;

    // A mismatching result clears the flag, darkening the match lamp at once.
    assign w_flag_next = (r_state == S_DONE) ? (r_best_idx == exp_idx) : r_match_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_match_flag  <= 1'b0;
            r_match_led_n <= 1'b1;
        end else begin
            r_match_flag  <= w_flag_next;
            r_match_led_n <= ~((w_cnt_next != 32'd0) && w_flag_next);
        end
    end

    assign match_led_n = r_match_led_n;
`endif

endmodule
`default_nettype wire

// File: doc/output_argmax_led.md
# output_argmax_led

Result indicator for the MNIST inference output. It accepts a packed vector of NUM_CLASSES signed class scores and finds the winning class (argmax) with a serial scan. It then reports the class index and lights one active-low LED per class for a programmable hold time. It sits at the accelerator output in place of the fixed-pattern LED checker and drives board LEDs directly.

## Interface
Parameters:
- NUM_CLASSES, 10, number of class scores; must be ≥2
- SCORE_W, 8, width of each score (signed two's complement)
- HOLD_CYCLES, 75000, number of cycles the LED stays lit per result; 0 to 2^32-1
- IDX_W (localparam), $clog2(NUM_CLASSES), width of the index

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- din_valid  in  1  score vector valid; accepted only when busy=0
- din  in  NUM_CLASSES*SCORE_W  packed scores; class k = din[k*SCORE_W +: SCORE_W]
- busy  out  1  high while a vector is captured or being scanned
- result_valid  out  1  one-cycle pulse when result_idx is updated
- result_idx  out  IDX_W  winning class, held until the next result
- led_n  out  NUM_CLASSES  active-low one-hot; bit result_idx low during hold, otherwise all ones
- exp_idx  in  IDX_W  expected class (only with OUTPUT_ARGMAX_LED_MATCH_EN)
- match_led_n  out  1  active-low match indicator (only with OUTPUT_ARGMAX_LED_MATCH_EN)

## Operation
- FSM states: IDLE, SCAN, DONE.
  - IDLE: on din_valid=1, register din, set best_val=class 0, best_idx=0, scan index i=1, go to SCAN.
  - SCAN: each cycle compare class i (signed) against best_val. If strictly greater, replace best_val and best_idx. Increment i. After the comparison for i=NUM_CLASSES-1, go to DONE.
  - DONE: register result_idx=best_idx and result_valid=1. Load hold counter with HOLD_CYCLES. Return to IDLE.
- Ties: the lowest index wins, because only a strictly greater score replaces the current best.
- din_valid while busy=1 is ignored; there is no queueing.
- Hold counter is 32 bits and decrements to 0, then stays at 0. led_n lights bit result_idx low while counter≠0, otherwise all ones.
- A new result during an active hold reloads the counter and moves the lit LED to the new index.
- HOLD_CYCLES=0: no LED is ever lit; result_valid and result_idx still update.
- Reset values: state IDLE, busy=0, result_valid=0, result_idx=0, led_n=all ones, match_led_n=1, counter=0.
- Reset asserted mid-scan aborts the scan immediately. No result_valid is produced.

## Timing
- Edge E0: din_valid is sampled in IDLE and the vector is captured. busy goes high after E0.
- Edges E1..E(NUM_CLASSES-1): one comparison per edge.
- Edge E(NUM_CLASSES): result_valid, result_idx, and led_n update together.
  - busy goes low after this edge.
  - result_valid is high for exactly one cycle.
  - Latency is NUM_CLASSES cycles from acceptance to result (10 for the default).
- Back-to-back: a new vector can be accepted at E(NUM_CLASSES+1). Throughput is one vector per NUM_CLASSES+1 cycles.
- LED low for exactly HOLD_CYCLES cycles, starting the cycle after E(NUM_CLASSES).
- All outputs are registered.

## Configuration
- OUTPUT_ARGMAX_LED_MATCH_EN defined:
  - exp_idx and match_led_n exist.
  - At the DONE edge, a match flag registers (best_idx == exp_idx).
  - match_led_n is low while the hold counter≠0 and the flag is set.
  - A mismatch result clears the flag, so match_led_n returns high immediately even during a hold.
- Not defined: exp_idx and match_led_n are absent from the port list, and no compare logic is built.

## Test plan
(NUM_CLASSES=10, SCORE_W=8, HOLD_CYCLES=20.)
- din=80'h331946000000120C1B00 with a single-cycle valid -> result_valid 10 cycles after acceptance; result_idx=7; led_n=10'h37F for 20 cycles, then 10'h3FF.
- Signed order: class0=8'h80, class3=8'hFF, all others 8'h90 -> result_idx=3.
- Tie: class2=class5=8'h7F, others 8'h00 -> result_idx=2.
- din_valid held high continuously -> second vector accepted 11 cycles after the first. Vectors presented while busy=1 are ignored. The hold counter restarts at the second result, and the LED moves to the new index.
- rst_n pulsed low at the 4th SCAN cycle -> busy=0 and led_n=10'h3FF immediately; no result_valid pulse. A subsequent vector completes normally.
- With OUTPUT_ARGMAX_LED_MATCH_EN, first-scenario din:
  - exp_idx=7 -> match_led_n low for 20 cycles.
  - exp_idx=3 -> match_led_n stays 1.
